// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared floating-point definitions: RISC-V FCLASS bit
//                indices, packed IEEE 754 operand layouts for single and
//                double precision, and the exponent-bias helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_pkg;

  // FCLASS result bit positions (RISC-V ordering)
  localparam int FCLASS_NEG_INF  = 0;
  localparam int FCLASS_NEG_NORM = 1;
  localparam int FCLASS_NEG_SUB  = 2;
  localparam int FCLASS_NEG_ZERO = 3;
  localparam int FCLASS_POS_ZERO = 4;
  localparam int FCLASS_POS_SUB  = 5;
  localparam int FCLASS_POS_NORM = 6;
  localparam int FCLASS_POS_INF  = 7;
  localparam int FCLASS_SNAN     = 8;
  localparam int FCLASS_QNAN     = 9;
  localparam int FCLASS_W        = 10;

  // Packed operand layouts {sign, biased exponent, fraction}
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] frac;
  } fp64_t;

  // IEEE 754 exponent bias for an exponent field of exp_w bits
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_lzc
//  Description : Parametrised leading-zero counter. Counts zeros from the
//                MSB down to the first set bit; returns W when the input is
//                all zeros.
//  Ports       : in_bits [W-1:0]      value to scan
//                cnt     [CNT_W-1:0]  number of leading zeros (0..W)
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_lzc #(
  parameter int W     = 23,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     in_bits,
  output logic [CNT_W-1:0] cnt
);

  // Scan from LSB upward; the last (highest) set bit seen wins, which gives
  // the distance from the MSB. A priority chain keeps this purely
  // combinational and lets synthesis build whatever tree suits the width.
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (in_bits[i]) begin
        cnt = CNT_W'(W - 1 - i);
      end
    end
  end

endmodule : fpu_lzc
`default_nettype wire

// File: rtl/fpu_unpack_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_unpack_norm_pipe
//  Description : Two-stage pipelined IEEE 754 unpacker. Stage 1 registers
//                the operand fields, class flags and the fraction's leading-
//                zero count; stage 2 produces the unbiased exponent, the
//                normalised significand (subnormals shifted so the integer
//                bit is set) and the RISC-V FCLASS mask.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                in_valid/in_ready/in_data  operand handshake {sign,exp,frac}
//                out_valid/out_ready      result handshake
//                out_sign, out_exp, out_sig, out_class   result fields
//                out_is_zero/inf/nan/snan/subnormal      class flags
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_unpack_norm_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = fp_bias(EXP_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [EXP_W+1:0]         out_exp,
  output logic [MAN_W:0]           out_sig,
  output logic [FCLASS_W-1:0]      out_class,
  output logic                     out_is_zero,
  output logic                     out_is_inf,
  output logic                     out_is_nan,
  output logic                     out_is_snan,
  output logic                     out_is_subnormal
);

  localparam int XW    = EXP_W + 2;
  localparam int LZC_W = $clog2(MAN_W + 1);
  localparam int SH_W  = LZC_W + 1;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [XW-1:0]    BIAS_X    = XW'(BIAS);
  localparam logic [XW-1:0]    BIAS_P1_X = XW'(BIAS + 1);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_can_load;
  logic s1_can_load;

  assign s2_can_load = !out_valid_q || out_ready;
  assign s1_can_load = !s1_valid_q || s2_can_load;
  assign in_ready    = s1_can_load;

  // --------------------------------------------------------------------------
  // Stage 1: field split, classification, leading-zero count
  // --------------------------------------------------------------------------
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_frac;
  logic             in_exp_zero;
  logic             in_exp_ones;
  logic             in_frac_zero;
  logic [LZC_W-1:0] in_lzc;

  assign in_sign      = in_data[EXP_W+MAN_W];
  assign in_exp       = in_data[EXP_W+MAN_W-1:MAN_W];
  assign in_frac      = in_data[MAN_W-1:0];
  assign in_exp_zero  = (in_exp == '0);
  assign in_exp_ones  = (in_exp == EXP_ONES);
  assign in_frac_zero = (in_frac == '0);

  fpu_lzc #(
    .W     (MAN_W),
    .CNT_W (LZC_W)
  ) u_lzc (
    .in_bits (in_frac),
    .cnt     (in_lzc)
  );

  logic             s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0] s1_exp_q,  s1_exp_d;
  logic [MAN_W-1:0] s1_frac_q, s1_frac_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_sub_q,  s1_sub_d;
  logic             s1_inf_q,  s1_inf_d;
  logic             s1_nan_q,  s1_nan_d;
  logic [LZC_W-1:0] s1_lzc_q,  s1_lzc_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_frac_d  = s1_frac_q;
    s1_zero_d  = s1_zero_q;
    s1_sub_d   = s1_sub_q;
    s1_inf_d   = s1_inf_q;
    s1_nan_d   = s1_nan_q;
    s1_lzc_d   = s1_lzc_q;
    if (s1_can_load) begin
      s1_valid_d = in_valid;
      // Data only moves with a real operand so idle cycles do not toggle it.
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_exp_d  = in_exp;
        s1_frac_d = in_frac;
        s1_zero_d = in_exp_zero &&  in_frac_zero;
        s1_sub_d  = in_exp_zero && !in_frac_zero;
        s1_inf_d  = in_exp_ones &&  in_frac_zero;
        s1_nan_d  = in_exp_ones && !in_frac_zero;
        s1_lzc_d  = in_lzc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_zero_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_lzc_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_frac_q  <= s1_frac_d;
      s1_zero_q  <= s1_zero_d;
      s1_sub_q   <= s1_sub_d;
      s1_inf_q   <= s1_inf_d;
      s1_nan_q   <= s1_nan_d;
      s1_lzc_q   <= s1_lzc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: exponent / significand / FCLASS
  // --------------------------------------------------------------------------
  logic [SH_W-1:0]     sub_shamt;
  logic [MAN_W:0]      sub_sig;
  logic [XW-1:0]       norm_exp;
  logic [XW-1:0]       sub_exp;
  logic                s1_qnan;
  logic [XW-1:0]       res_exp;
  logic [MAN_W:0]      res_sig;
  logic [FCLASS_W-1:0] res_class;

  // A subnormal's first set bit sits lzc places below the fraction MSB, so
  // shifting the {0,frac} field by lzc+1 lands it on the integer bit. Its
  // value is frac * 2^(1-BIAS-MAN_W), which after the shift gives
  // -BIAS - lzc as the exponent.
  assign sub_shamt = SH_W'(s1_lzc_q) + SH_W'(1);
  assign sub_sig   = {1'b0, s1_frac_q} << sub_shamt;
  assign norm_exp  = XW'(s1_exp_q) - BIAS_X;
  assign sub_exp   = (XW'(0) - BIAS_X) - XW'(s1_lzc_q);
  assign s1_qnan   = s1_frac_q[MAN_W-1];

  always_comb begin
    res_exp   = '0;
    res_sig   = '0;
    res_class = '0;
    if (s1_nan_q) begin
      // Payload is passed through untouched; signalling NaNs stay signalling.
      res_exp = BIAS_P1_X;
      res_sig = {1'b1, s1_frac_q};
      if (s1_qnan) begin
        res_class[FCLASS_QNAN] = 1'b1;
      end else begin
        res_class[FCLASS_SNAN] = 1'b1;
      end
    end else if (s1_inf_q) begin
      res_exp = BIAS_P1_X;
      res_sig = {1'b1, {MAN_W{1'b0}}};
      res_class[s1_sign_q ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
    end else if (s1_zero_q) begin
      res_class[s1_sign_q ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
    end else if (s1_sub_q) begin
      res_exp = sub_exp;
      res_sig = sub_sig;
      res_class[s1_sign_q ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
    end else begin
      res_exp = norm_exp;
      res_sig = {1'b1, s1_frac_q};
      res_class[s1_sign_q ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
    end
  end

  logic                out_sign_q,  out_sign_d;
  logic [XW-1:0]       out_exp_q,   out_exp_d;
  logic [MAN_W:0]      out_sig_q,   out_sig_d;
  logic [FCLASS_W-1:0] out_class_q, out_class_d;
  logic                out_zero_q,  out_zero_d;
  logic                out_inf_q,   out_inf_d;
  logic                out_nan_q,   out_nan_d;
  logic                out_snan_q,  out_snan_d;
  logic                out_sub_q,   out_sub_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_sig_d   = out_sig_q;
    out_class_d = out_class_q;
    out_zero_d  = out_zero_q;
    out_inf_d   = out_inf_q;
    out_nan_d   = out_nan_q;
    out_snan_d  = out_snan_q;
    out_sub_d   = out_sub_q;
    if (s2_can_load) begin
      out_valid_d = s1_valid_q;
      // Result fields only change when a new operand arrives, so they stay
      // stable while the consumer stalls.
      if (s1_valid_q) begin
        out_sign_d  = s1_sign_q;
        out_exp_d   = res_exp;
        out_sig_d   = res_sig;
        out_class_d = res_class;
        out_zero_d  = s1_zero_q;
        out_inf_d   = s1_inf_q;
        out_nan_d   = s1_nan_q;
        out_snan_d  = s1_nan_q && !s1_qnan;
        out_sub_d   = s1_sub_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_class_q <= '0;
      out_zero_q  <= 1'b0;
      out_inf_q   <= 1'b0;
      out_nan_q   <= 1'b0;
      out_snan_q  <= 1'b0;
      out_sub_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_sig_q   <= out_sig_d;
      out_class_q <= out_class_d;
      out_zero_q  <= out_zero_d;
      out_inf_q   <= out_inf_d;
      out_nan_q   <= out_nan_d;
      out_snan_q  <= out_snan_d;
      out_sub_q   <= out_sub_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_sign         = out_sign_q;
  assign out_exp          = out_exp_q;
  assign out_sig          = out_sig_q;
  assign out_class        = out_class_q;
  assign out_is_zero      = out_zero_q;
  assign out_is_inf       = out_inf_q;
  assign out_is_nan       = out_nan_q;
  assign out_is_snan      = out_snan_q;
  assign out_is_subnormal = out_sub_q;

endmodule : fpu_unpack_norm_pipe
`default_nettype wire

// File: tb/tb_fpu_unpack_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_unpack_norm_pipe
//  Description : Self-checking bench for fpu_unpack_norm_pipe (single and
//                double precision instances) using a value-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_unpack_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single precision DUT ----------------
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_sig;
  logic [9:0]  out_class;
  logic        out_is_zero, out_is_inf, out_is_nan, out_is_snan, out_is_subnormal;

  fpu_unpack_norm_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig), .out_class(out_class),
    .out_is_zero(out_is_zero), .out_is_inf(out_is_inf), .out_is_nan(out_is_nan),
    .out_is_snan(out_is_snan), .out_is_subnormal(out_is_subnormal)
  );

  // ---------------- double precision DUT ----------------
  logic        d_in_valid;
  logic        d_in_ready;
  logic [63:0] d_in_data;
  logic        d_out_valid;
  logic        d_out_ready;
  logic        d_out_sign;
  logic [12:0] d_out_exp;
  logic [52:0] d_out_sig;
  logic [9:0]  d_out_class;
  logic        d_zero, d_inf, d_nan, d_snan, d_sub;

  fpu_unpack_norm_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_sign(d_out_sign), .out_exp(d_out_exp), .out_sig(d_out_sig), .out_class(d_out_class),
    .out_is_zero(d_zero), .out_is_inf(d_inf), .out_is_nan(d_nan),
    .out_is_snan(d_snan), .out_is_subnormal(d_sub)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- value-level reference model ----------------
  typedef struct {
    bit     sign;
    longint e;
    longint sig;
    int     cidx;
    bit     z, inf, nan, snan, sub;
  } mdl_t;

  function automatic mdl_t model(input logic [63:0] op, input int ew, input int mw);
    mdl_t   m;
    longint bias, ex, fr, emax, hidden;
    bias   = (longint'(1) << (ew - 1)) - 1;
    emax   = (longint'(1) << ew) - 1;
    hidden = longint'(1) << mw;
    fr     = longint'(op & ((64'd1 << mw) - 1));
    ex     = longint'((op >> mw) & ((64'd1 << ew) - 1));
    m.sign = op[ew+mw];
    m.z = 0; m.inf = 0; m.nan = 0; m.snan = 0; m.sub = 0;
    if (ex == 0 && fr == 0) begin
      m.z = 1; m.e = 0; m.sig = 0; m.cidx = m.sign ? 3 : 4;
    end else if (ex == 0) begin
      // value = fr * 2^(1-bias-mw): double until the hidden bit is reached
      m.sub = 1; m.sig = fr; m.e = 1 - bias;
      while (m.sig < hidden) begin
        m.sig = m.sig * 2;
        m.e   = m.e - 1;
      end
      m.cidx = m.sign ? 2 : 5;
    end else if (ex == emax && fr == 0) begin
      m.inf = 1; m.e = bias + 1; m.sig = hidden; m.cidx = m.sign ? 0 : 7;
    end else if (ex == emax) begin
      m.nan = 1; m.e = bias + 1; m.sig = hidden + fr;
      m.snan = (fr < (hidden / 2));
      m.cidx = m.snan ? 8 : 9;
    end else begin
      m.e = ex - bias; m.sig = hidden + fr; m.cidx = m.sign ? 1 : 6;
    end
    return m;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] op;
    bit          lit;
    longint      le;
    longint      ls;
    int          lc;
    bit          lat;
    int          acc;
  } ent_t;

  ent_t q[$];

  bit     cur_lit, cur_lat;
  longint cur_le, cur_ls;
  int     cur_lc;

  ent_t        e;
  mdl_t        m;
  bit          held = 0;
  logic [9:0]  h_exp;
  logic [23:0] h_sig;
  logic [9:0]  h_class;
  logic        h_sign;

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_sig",   longint'(out_sig),   longint'(h_sig));
        check("hold_exp",   longint'(out_exp),   longint'(h_exp));
        check("hold_class", longint'(out_class), longint'(h_class));
        check("hold_sign",  longint'(out_sign),  longint'(h_sign));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got out_valid=1 with sig %0h, expected no result", out_sig);
        end else begin
          e = q.pop_front();
          m = model({32'b0, e.op}, 8, 23);
          check($sformatf("sign[%08h]", e.op),  longint'(out_sign), longint'(m.sign));
          check($sformatf("exp[%08h]", e.op),   longint'($signed(out_exp)), m.e);
          check($sformatf("sig[%08h]", e.op),   longint'(out_sig), m.sig);
          check($sformatf("class[%08h]", e.op), longint'(out_class), longint'(1) << m.cidx);
          check($sformatf("flags[%08h]", e.op),
                longint'({out_is_zero, out_is_inf, out_is_nan, out_is_snan, out_is_subnormal}),
                longint'({m.z, m.inf, m.nan, m.snan, m.sub}));
          if (e.lit) begin
            check($sformatf("lit_exp[%08h]", e.op),   longint'($signed(out_exp)), e.le);
            check($sformatf("lit_sig[%08h]", e.op),   longint'(out_sig), e.ls);
            check($sformatf("lit_class[%08h]", e.op), longint'(out_class), longint'(1) << e.lc);
          end
          if (e.lat) check($sformatf("latency[%08h]", e.op), longint'(cyc - e.acc), 2);
        end
      end
      held    = out_valid && !out_ready;
      h_exp   = out_exp;
      h_sig   = out_sig;
      h_class = out_class;
      h_sign  = out_sign;
      if (in_valid && in_ready) begin
        q.push_back('{op: in_data, lit: cur_lit, le: cur_le, ls: cur_ls, lc: cur_lc,
                      lat: cur_lat, acc: cyc});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_ready = 0;

  task automatic send(input logic [31:0] op, input bit lit, input longint le,
                      input longint ls, input int lc, input bit lat);
    bit fire;
    int n;
    in_valid = 1'b1;
    in_data  = op;
    cur_lit  = lit; cur_le = le; cur_ls = ls; cur_lc = lc; cur_lat = lat;
    n = 0;
    fire = 0;
    while (!fire && n < 200) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    end
    if (!fire) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    cur_lit  = 0;
    cur_lat  = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", longint'(q.size()), 0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  ex;
    logic [22:0] fr;
    case ($urandom_range(0, 3))
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      default: ex = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 3))
      0:       fr = '0;
      1:       fr = 23'd1 << $urandom_range(0, 22);
      default: fr = 23'($urandom);
    endcase
    return {1'($urandom), ex, fr};
  endfunction

  task automatic dbl(input logic [63:0] op, input longint le, input longint ls);
    int n;
    mdl_t dm;
    bit fire;
    d_in_valid = 1'b1;
    d_in_data  = op;
    @(negedge clk);
    fire = d_in_ready;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    check("d_accept", longint'(fire), 1);
    n = 0;
    @(negedge clk);
    while (!d_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("d_out_valid", longint'(d_out_valid), 1);
    dm = model(op, 11, 52);
    check($sformatf("d_lit_exp[%016h]", op), longint'($signed(d_out_exp)), le);
    check($sformatf("d_lit_sig[%016h]", op), longint'(d_out_sig), ls);
    check($sformatf("d_exp[%016h]", op),     longint'($signed(d_out_exp)), dm.e);
    check($sformatf("d_sig[%016h]", op),     longint'(d_out_sig), dm.sig);
    check($sformatf("d_class[%016h]", op),   longint'(d_out_class), longint'(1) << dm.cidx);
    check($sformatf("d_flags[%016h]", op),
          longint'({d_zero, d_inf, d_nan, d_snan, d_sub}),
          longint'({dm.z, dm.inf, dm.nan, dm.snan, dm.sub}));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] bp_ops [4];

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
    cur_lit = 0; cur_lat = 0; cur_le = 0; cur_ls = 0; cur_lc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready",  longint'(in_ready), 1);
    check("rst_out_sig",   longint'(out_sig), 0);
    check("rst_out_exp",   longint'(out_exp), 0);
    check("rst_out_class", longint'(out_class), 0);

    // back-to-back normals with latency check
    send(32'h3F800000, 1, 0,    64'h800000, 6, 1);
    send(32'hC0000000, 1, 1,    64'h800000, 1, 1);
    // subnormals and specials
    send(32'h00000001, 1, -149, 64'h800000, 5, 0);
    send(32'h80400000, 1, -127, 64'h800000, 2, 0);
    send(32'hFF800000, 1, 128,  64'h800000, 0, 0);
    send(32'h7FC00000, 1, 128,  64'hC00000, 9, 0);
    send(32'h7F800001, 1, 128,  64'h800001, 8, 0);
    send(32'h80000000, 1, 0,    64'h0,      3, 0);
    send(32'h007FFFFF, 1, -127, 64'hFFFFFE, 5, 0);
    drain();

    // backpressure: 4 operands offered while the consumer stalls 5 cycles
    bp_ops[0] = 32'h40490FDB; bp_ops[1] = 32'h00000003;
    bp_ops[2] = 32'hFF800001; bp_ops[3] = 32'h80000000;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k < 4);
      in_data  = bp_ops[k % 4];
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", longint'(k), 2);
    check("bp_in_ready", longint'(in_ready), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = k; i < 4; i++) send(bp_ops[i], 0, 0, 0, 0, 0);
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    send(32'h3F800000, 0, 0, 0, 0, 0);
    send(32'h41200000, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("rst2_out_valid", longint'(out_valid), 0);
    check("rst2_out_sig",   longint'(out_sig), 0);
    check("rst2_out_exp",   longint'(out_exp), 0);
    check("rst2_out_class", longint'(out_class), 0);
    check("rst2_in_ready",  longint'(in_ready), 1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // randomized traffic with random stalls
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        send(rand_op(), 0, 0, 0, 0, 0);
      end
    end
    rand_ready = 0;
    out_ready  = 1'b1;
    drain();

    // double precision
    dbl(64'h0000000000000001, -1074, 64'h0010000000000000);
    dbl(64'h3FF0000000000000, 0,     64'h0010000000000000);
    dbl(64'hFFF0000000000000, 1024,  64'h0010000000000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fpu_unpack_norm_pipe
`default_nettype wire
